// File: rtl/rx_controller.sv
`default_nettype none
// ============================================================================
//  Module      : rx_controller
//  Description : USB full-speed receive control unit. Detects packet start,
//                validates the SYNC byte, counts decoded bits, strobes one
//                FIFO write per completed data byte and flags framing errors.
//  Revision    : 1.0  initial release
// ============================================================================
module rx_controller #(
    parameter logic [7:0] SYNC_BYTE = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SYNC_RCV = 4'd1;
    localparam logic [3:0] S_CHK_SYNC = 4'd2;
    localparam logic [3:0] S_DATA_RCV = 4'd3;
    localparam logic [3:0] S_STORE    = 4'd4;
    localparam logic [3:0] S_EOP_DONE = 4'd5;
    localparam logic [3:0] S_ERR_WAIT = 4'd6;
    localparam logic [3:0] S_ERR_EOP  = 4'd7;
    localparam logic [3:0] S_ERR_IDLE = 4'd8;

    localparam logic [2:0] c_LAST_BIT = 3'd7;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [2:0] r_bit_cnt;
    logic       w_eop_shift;
    logic       w_byte_done;

    // An EOP-qualified shift always wins over a byte completing on the same bit.
    assign w_eop_shift = shift_enable & eop;
    assign w_byte_done = shift_enable & ~eop & (r_bit_cnt == c_LAST_BIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bit counter: restarts at each SYNC and at the first data bit, wraps per byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
        end else if ((w_next_state == S_SYNC_RCV) && (r_state != S_SYNC_RCV)) begin
            r_bit_cnt <= 3'd0;
        end else if (r_state == S_CHK_SYNC) begin
            r_bit_cnt <= 3'd0;
        end else if (shift_enable && ((r_state == S_SYNC_RCV) || (r_state == S_DATA_RCV))) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (d_edge) w_next_state = S_SYNC_RCV;
            end
            S_SYNC_RCV: begin
                if (w_eop_shift)      w_next_state = S_ERR_EOP;
                else if (w_byte_done) w_next_state = S_CHK_SYNC;
            end
            S_CHK_SYNC: begin
                if (rcv_data == SYNC_BYTE) w_next_state = S_DATA_RCV;
                else                       w_next_state = S_ERR_WAIT;
            end
            S_DATA_RCV: begin
                if (w_eop_shift) begin
                    if (r_bit_cnt == 3'd0) w_next_state = S_EOP_DONE;
                    else                   w_next_state = S_ERR_EOP;
                end else if (w_byte_done) begin
                    w_next_state = S_STORE;
                end
            end
            S_STORE: begin
                w_next_state = S_DATA_RCV;
            end
            S_EOP_DONE: begin
                if (d_edge) w_next_state = S_IDLE;
            end
            S_ERR_WAIT: begin
                if (w_eop_shift) w_next_state = S_ERR_EOP;
            end
            S_ERR_EOP: begin
                if (d_edge) w_next_state = S_ERR_IDLE;
            end
            S_ERR_IDLE: begin
                if (d_edge) w_next_state = S_SYNC_RCV;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        rcving   = 1'b0;
        w_enable = 1'b0;
        r_error  = 1'b0;
        case (r_state)
            S_SYNC_RCV, S_CHK_SYNC, S_DATA_RCV, S_EOP_DONE: begin
                rcving = 1'b1;
            end
            S_STORE: begin
                rcving   = 1'b1;
                w_enable = 1'b1;
            end
            S_ERR_WAIT, S_ERR_EOP: begin
                rcving  = 1'b1;
                r_error = 1'b1;
            end
            S_ERR_IDLE: begin
                r_error = 1'b1;
            end
            default: begin
                rcving = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
